// File: rtl/ex_result_stage.sv
// ex_result_stage: captures ALU results, holds carry/zero/sign flags, resolves branches and hands
// results to writeback over valid/ready. Define EX_SKID_BUF_EN for a two-entry skid buffer.
module ex_result_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_result,
  input  logic               in_flag,
  input  logic               in_flag_upd,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_wr_en,
  input  logic [2:0]         in_br_cond,
  input  logic [DATA_W-1:0]  in_br_target,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_wr_en,
  output logic               carry_q,
  output logic               zero_q,
  output logic               sign_q,
  output logic               br_taken,
  output logic [DATA_W-1:0]  br_target
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  buf_state_e         state_r, state_s;
  logic               ready_r;
  logic               out_valid_r;
  logic               accept_s;
  logic               pop_s;
  logic               load_main_s;
  logic               taken_s;
  logic [DATA_W-1:0]  main_result_r;
  logic [RADDR_W-1:0] main_rd_r;
  logic               main_wr_en_r;
  logic               carry_r;
  logic               zero_r;
  logic               sign_r;
  logic               br_taken_r;
  logic [DATA_W-1:0]  br_target_r;
`ifdef EX_SKID_BUF_EN
  logic               load_skid_s;
  logic               shift_s;
  logic [DATA_W-1:0]  skid_result_r;
  logic [RADDR_W-1:0] skid_rd_r;
  logic               skid_wr_en_r;
`endif

  // Carry input is the flag value before this beat's own update.
  function automatic logic branch_taken(input logic [2:0] cond, input logic [DATA_W-1:0] res,
                                        input logic carry);
    logic tk;
    case (cond)
      3'd0:    tk = 1'b0;
      3'd1:    tk = (res == {DATA_W{1'b0}});
      3'd2:    tk = (res != {DATA_W{1'b0}});
      3'd3:    tk = res[DATA_W-1];
      3'd4:    tk = carry;
      3'd5:    tk = ~carry;
      3'd6:    tk = 1'b1;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  assign accept_s = in_valid & in_ready;
  assign pop_s    = out_valid_r & out_ready;
  assign taken_s  = branch_taken(in_br_cond, in_result, carry_r);

`ifdef EX_SKID_BUF_EN
  assign in_ready = ready_r & ~flush;
`else
  assign in_ready = ready_r & ~flush & (~out_valid_r | out_ready);
`endif

  assign out_valid  = out_valid_r;
  assign out_result = main_result_r;
  assign out_rd     = main_rd_r;
  assign out_wr_en  = main_wr_en_r;
  assign carry_q    = carry_r;
  assign zero_q     = zero_r;
  assign sign_q     = sign_r;
  assign br_taken   = br_taken_r;
  assign br_target  = br_target_r;

  // Buffer next-state and entry load controls.
  always_comb begin
    state_s     = state_r;
    load_main_s = 1'b0;
`ifdef EX_SKID_BUF_EN
    load_skid_s = 1'b0;
    shift_s     = 1'b0;
`endif
    if (flush) begin
      state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            load_main_s = 1'b1;
            state_s     = ST_ONE;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && pop_s) begin
            load_main_s = 1'b1;
            state_s     = ST_ONE;
          end else if (accept_s) begin
`ifdef EX_SKID_BUF_EN
            load_skid_s = 1'b1;
            state_s     = ST_TWO;
`else
            load_main_s = 1'b1;
            state_s     = ST_ONE;
`endif
          end else if (pop_s) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_TWO: begin
`ifdef EX_SKID_BUF_EN
          if (pop_s) begin
            shift_s = 1'b1;
            state_s = ST_ONE;
          end else begin
            state_s = ST_TWO;
          end
`else
          state_s = ST_EMPTY;
`endif
        end
        default: state_s = ST_EMPTY;
      endcase
    end
  end

  // Buffer state, valid and ready registers; ready stays low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      out_valid_r <= (state_s != ST_EMPTY);
`ifdef EX_SKID_BUF_EN
      ready_r     <= (state_s != ST_TWO);
`else
      ready_r     <= 1'b1;
`endif
    end
  end

  // Output-facing entry; in skid mode it refills from the skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_result_r <= {DATA_W{1'b0}};
      main_rd_r     <= {RADDR_W{1'b0}};
      main_wr_en_r  <= 1'b0;
    end else if (load_main_s) begin
      main_result_r <= in_result;
      main_rd_r     <= in_rd;
      main_wr_en_r  <= in_wr_en;
`ifdef EX_SKID_BUF_EN
    end else if (shift_s) begin
      main_result_r <= skid_result_r;
      main_rd_r     <= skid_rd_r;
      main_wr_en_r  <= skid_wr_en_r;
`endif
    end else begin
      main_result_r <= main_result_r;
      main_rd_r     <= main_rd_r;
      main_wr_en_r  <= main_wr_en_r;
    end
  end

`ifdef EX_SKID_BUF_EN
  // Skid entry catches the beat accepted while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_result_r <= {DATA_W{1'b0}};
      skid_rd_r     <= {RADDR_W{1'b0}};
      skid_wr_en_r  <= 1'b0;
    end else if (load_skid_s) begin
      skid_result_r <= in_result;
      skid_rd_r     <= in_rd;
      skid_wr_en_r  <= in_wr_en;
    end else begin
      skid_result_r <= skid_result_r;
      skid_rd_r     <= skid_rd_r;
      skid_wr_en_r  <= skid_wr_en_r;
    end
  end
`endif

  // Architectural flags and the registered branch pulse; flush blocks accept so no pulse follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      sign_r      <= 1'b0;
      br_taken_r  <= 1'b0;
      br_target_r <= {DATA_W{1'b0}};
    end else begin
      br_taken_r <= accept_s & taken_s;
      if (accept_s) begin
        zero_r <= (in_result == {DATA_W{1'b0}});
        sign_r <= in_result[DATA_W-1];
        if (in_flag_upd) begin
          carry_r <= in_flag;
        end else begin
          carry_r <= carry_r;
        end
        if (taken_s) begin
          br_target_r <= in_br_target;
        end else begin
          br_target_r <= br_target_r;
        end
      end else begin
        zero_r      <= zero_r;
        sign_r      <= sign_r;
        carry_r     <= carry_r;
        br_target_r <= br_target_r;
      end
    end
  end

endmodule
